// File: rtl/logic_pipe_pkg.sv
// Shared op codes and the per-bit logic function used by the logic_pipe lane.
// The function works on one bit so the unit scales to any WIDTH via generate.
package logic_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'b100;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b101;

  // Returns {err, f} for one bit position; reserved codes force f=0, err=1.
  function automatic logic [1:0] logic_op(input logic [OP_W-1:0] op,
                                          input logic a,
                                          input logic b);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_NOR:   r = {1'b0, ~(a | b)};
      OP_ANDN:  r = {1'b0, a & ~b};
      OP_PASSA: r = {1'b0, a};
      default:  r = 2'b10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_slice.sv
// One valid/ready register slice; ready is combinational from downstream,
// so a full slice that drains this cycle reloads in the same cycle.
module logic_pipe_slice #(
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          valid_reg;
  logic [DW-1:0] data_reg;

  assign up_ready = !valid_reg || dn_ready;
  assign dn_valid = valid_reg;
  assign dn_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (up_ready) begin
      valid_reg <= up_valid;
      if (up_valid) begin
        data_reg <= up_data;
      end
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic lane: result and flags are formed before the first
// slice, then carried unchanged through STAGES valid/ready slices.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             err
);

  localparam int DW = WIDTH + 2;

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] err_bits;
  logic             res_err;

  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  ready_c;
  logic [DW-1:0]    data_c [STAGES+1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign {err_bits[gi], res[gi]} = logic_op(op, a[gi], b[gi]);
    end
  endgenerate

  assign res_err   = |err_bits;
  assign valid_c[0] = in_valid;
  assign data_c[0]  = {res_err, ~|res, res};
  assign in_ready   = ready_c[0];
  assign ready_c[STAGES] = out_ready;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      logic_pipe_slice #(.DW(DW)) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (valid_c[gi]),
        .up_ready (ready_c[gi]),
        .up_data  (data_c[gi]),
        .dn_valid (valid_c[gi+1]),
        .dn_ready (ready_c[gi+1]),
        .dn_data  (data_c[gi+1])
      );
    end
  endgenerate

  // Empty last slice may hold stale data; gate everything off when not valid.
  assign out_valid = valid_c[STAGES];
  assign f         = out_valid ? data_c[STAGES][WIDTH-1:0] : '0;
  assign zero      = out_valid & data_c[STAGES][WIDTH];
  assign err       = out_valid & data_c[STAGES][WIDTH+1];

endmodule
